// File: rtl/cpu_control_unit.sv
// Multicycle control FSM for the RV64I datapath: IDLE -> DECODE -> EXECUTE -> [MEMORY] -> [WRITEBACK].
// Define CU_EXT_ALU_EN to accept sll/srl/slt and slli/srli/slti (ALU codes 101/110/111).
module cpu_control_unit #(
    parameter int unsigned WORDSIZE = 64
) (
    input  logic        cu_clk,
    input  logic        cu_rst,
    input  logic [31:0] cu_instr,
    input  logic        cu_instr_valid,
    output logic        cu_instr_ready,
    output logic [4:0]  cu_rf_addr_a,
    output logic [4:0]  cu_rf_addr_b,
    output logic [4:0]  cu_rf_write_addr,
    output logic        cu_rf_write_en,
    output logic [11:0] cu_immediate,
    output logic        cu_mux_0_sel,
    output logic        cu_mux_1_sel,
    output logic        cu_mux_2_sel,
    output logic [2:0]  cu_alu_operation,
    output logic        cu_dmem_write_en,
    output logic        cu_done,
    output logic        cu_illegal
);

`ifdef CU_EXT_ALU_EN
    localparam bit EXT_EN = 1'b1;
`else
    localparam bit EXT_EN = 1'b0;
`endif

    // RV64 shift immediates carry a log2(WORDSIZE)-bit shamt; bits above it must be zero
    localparam int unsigned SHAMT_W = $clog2(WORDSIZE);

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_SD = 7'b0100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b101;
    localparam logic [2:0] ALU_SRL = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXECUTE,
        S_MEMORY,
        S_WRITEBACK
    } state_t;

    typedef enum logic [1:0] {
        K_ALU,
        K_LD,
        K_SD,
        K_ILL
    } kind_t;

    typedef struct packed {
        kind_t       kind;
        logic [2:0]  alu;
        logic [11:0] imm;
        logic        mux_0;
        logic        mux_1;
    } dec_t;

    // Classify one instruction word and derive its static control fields
    function automatic dec_t decode(input logic [31:0] instr);
        logic [6:0] funct7;
        logic [2:0] funct3;
        logic       shamt_ok;
        logic       ok;
        logic [2:0] op;
        dec_t       d;
        funct7   = instr[31:25];
        funct3   = instr[14:12];
        shamt_ok = (instr[31:20] >> SHAMT_W) == 12'd0;
        ok       = 1'b0;
        op       = ALU_ADD;
        d.kind   = K_ILL;
        d.alu    = ALU_ADD;
        d.imm    = instr[31:20];
        d.mux_0  = 1'b0;
        d.mux_1  = 1'b0;
        case (instr[6:0])
            OP_R: begin
                case (funct3)
                    3'b000: begin
                        ok = (funct7 == 7'h00) || (funct7 == 7'h20);
                        op = (funct7 == 7'h20) ? ALU_SUB : ALU_ADD;
                    end
                    3'b001: begin ok = EXT_EN && (funct7 == 7'h00); op = ALU_SLL; end
                    3'b010: begin ok = EXT_EN && (funct7 == 7'h00); op = ALU_SLT; end
                    3'b100: begin ok = (funct7 == 7'h00);           op = ALU_XOR; end
                    3'b101: begin ok = EXT_EN && (funct7 == 7'h00); op = ALU_SRL; end
                    3'b110: begin ok = (funct7 == 7'h00);           op = ALU_OR;  end
                    3'b111: begin ok = (funct7 == 7'h00);           op = ALU_AND; end
                    default: ok = 1'b0;
                endcase
                if (ok) d.kind = K_ALU;
            end
            OP_I: begin
                case (funct3)
                    3'b000: begin ok = 1'b1;               op = ALU_ADD; end
                    3'b001: begin ok = EXT_EN && shamt_ok; op = ALU_SLL; end
                    3'b010: begin ok = EXT_EN;             op = ALU_SLT; end
                    3'b100: begin ok = 1'b1;               op = ALU_XOR; end
                    3'b101: begin ok = EXT_EN && shamt_ok; op = ALU_SRL; end
                    3'b110: begin ok = 1'b1;               op = ALU_OR;  end
                    3'b111: begin ok = 1'b1;               op = ALU_AND; end
                    default: ok = 1'b0;
                endcase
                if (ok) begin
                    d.kind  = K_ALU;
                    d.mux_0 = 1'b1;
                end
            end
            OP_LD: begin
                if (funct3 == 3'b011) begin
                    ok      = 1'b1;
                    d.kind  = K_LD;
                    d.mux_0 = 1'b1;
                    d.mux_1 = 1'b1;
                end
            end
            OP_SD: begin
                if (funct3 == 3'b011) begin
                    ok      = 1'b1;
                    d.kind  = K_SD;
                    d.mux_0 = 1'b1;
                    d.imm   = {instr[31:25], instr[11:7]};
                end
            end
            default: ok = 1'b0;
        endcase
        // Illegal words keep ALU at add so extension codes never leak out
        if (ok) d.alu = op;
        return d;
    endfunction

    state_t      state;
    logic [31:0] instr_q;
    dec_t        dec;

    // In IDLE the incoming word is decoded so DECODE-cycle outputs are ready at the handshake edge
    always_comb begin
        dec = decode((state == S_IDLE) ? cu_instr : instr_q);
    end

    assign cu_instr_ready = (state == S_IDLE) && !cu_rst;

    always_ff @(posedge cu_clk) begin
        if (cu_rst) begin
            state            <= S_IDLE;
            instr_q          <= 32'd0;
            cu_rf_addr_a     <= 5'd0;
            cu_rf_addr_b     <= 5'd0;
            cu_rf_write_addr <= 5'd0;
            cu_rf_write_en   <= 1'b0;
            cu_immediate     <= 12'd0;
            cu_mux_0_sel     <= 1'b0;
            cu_mux_1_sel     <= 1'b0;
            cu_mux_2_sel     <= 1'b0;
            cu_alu_operation <= 3'd0;
            cu_dmem_write_en <= 1'b0;
            cu_done          <= 1'b0;
            cu_illegal       <= 1'b0;
        end else begin
            cu_rf_write_en   <= 1'b0;
            cu_dmem_write_en <= 1'b0;
            cu_mux_2_sel     <= 1'b0;
            cu_done          <= 1'b0;
            cu_illegal       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cu_instr_valid && cu_instr_ready) begin
                        instr_q          <= cu_instr;
                        cu_rf_addr_a     <= cu_instr[19:15];
                        cu_rf_addr_b     <= cu_instr[24:20];
                        cu_rf_write_addr <= cu_instr[11:7];
                        cu_immediate     <= dec.imm;
                        cu_mux_0_sel     <= dec.mux_0;
                        cu_mux_1_sel     <= dec.mux_1;
                        cu_alu_operation <= dec.alu;
                        cu_illegal       <= (dec.kind == K_ILL);
                        state            <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    state <= (dec.kind == K_ILL) ? S_IDLE : S_EXECUTE;
                end
                S_EXECUTE: begin
                    if (dec.kind == K_ALU) begin
                        cu_rf_write_en <= (cu_rf_write_addr != 5'd0);
                        cu_done        <= 1'b1;
                        state          <= S_WRITEBACK;
                    end else begin
                        if (dec.kind == K_SD) begin
                            cu_dmem_write_en <= 1'b1;
                            cu_mux_2_sel     <= 1'b1;
                            cu_done          <= 1'b1;
                        end
                        state <= S_MEMORY;
                    end
                end
                S_MEMORY: begin
                    if (dec.kind == K_LD) begin
                        cu_rf_write_en <= (cu_rf_write_addr != 5'd0);
                        cu_done        <= 1'b1;
                        state          <= S_WRITEBACK;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_WRITEBACK: state <= S_IDLE;
                default:     state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Self-checking bench for cpu_control_unit: directed plan vectors plus randomized words
// checked cycle by cycle against a mnemonic-level model of the instruction set.
module tb_cpu_control_unit;

`ifdef CU_EXT_ALU_EN
    localparam bit EXT = 1'b1;
`else
    localparam bit EXT = 1'b0;
`endif

    logic        cu_clk = 1'b0;
    logic        cu_rst;
    logic [31:0] cu_instr;
    logic        cu_instr_valid;
    logic        cu_instr_ready;
    logic [4:0]  cu_rf_addr_a;
    logic [4:0]  cu_rf_addr_b;
    logic [4:0]  cu_rf_write_addr;
    logic        cu_rf_write_en;
    logic [11:0] cu_immediate;
    logic        cu_mux_0_sel;
    logic        cu_mux_1_sel;
    logic        cu_mux_2_sel;
    logic [2:0]  cu_alu_operation;
    logic        cu_dmem_write_en;
    logic        cu_done;
    logic        cu_illegal;

    int n_cmp  = 0;
    int n_fail = 0;

    cpu_control_unit #(.WORDSIZE(64)) dut (
        .cu_clk           (cu_clk),
        .cu_rst           (cu_rst),
        .cu_instr         (cu_instr),
        .cu_instr_valid   (cu_instr_valid),
        .cu_instr_ready   (cu_instr_ready),
        .cu_rf_addr_a     (cu_rf_addr_a),
        .cu_rf_addr_b     (cu_rf_addr_b),
        .cu_rf_write_addr (cu_rf_write_addr),
        .cu_rf_write_en   (cu_rf_write_en),
        .cu_immediate     (cu_immediate),
        .cu_mux_0_sel     (cu_mux_0_sel),
        .cu_mux_1_sel     (cu_mux_1_sel),
        .cu_mux_2_sel     (cu_mux_2_sel),
        .cu_alu_operation (cu_alu_operation),
        .cu_dmem_write_en (cu_dmem_write_en),
        .cu_done          (cu_done),
        .cu_illegal       (cu_illegal)
    );

    always #5 cu_clk = ~cu_clk;

    typedef enum {X_ALU, X_LD, X_SD, X_BAD} xk_t;

    typedef struct {
        xk_t         kind;
        logic [2:0]  alu;
        logic [11:0] imm;
        logic        imm_care;
        logic        mux_0;
        logic        mux_1;
        int          last;
        logic        writes;
    } exp_t;

    // Base operation named by funct3, shared by R-type and I-type
    string base_tbl [8] = '{"add", "sll", "slt", "", "xor", "srl", "or", "and"};

    function automatic logic [2:0] alu_of(input string mn);
        if (mn == "sub") return 3'b001;
        if (mn == "and") return 3'b010;
        if (mn == "or")  return 3'b011;
        if (mn == "xor") return 3'b100;
        if (mn == "sll") return 3'b101;
        if (mn == "srl") return 3'b110;
        if (mn == "slt") return 3'b111;
        return 3'b000;
    endfunction

    function automatic bit is_ext(input string mn);
        return (mn == "sll") || (mn == "srl") || (mn == "slt");
    endfunction

    function automatic exp_t model(input logic [31:0] w);
        exp_t       e;
        string      base;
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = w[14:12];
        f7 = w[31:25];
        e.kind = X_BAD; e.alu = 3'b000; e.imm = 12'h000; e.imm_care = 1'b0;
        e.mux_0 = 1'b0; e.mux_1 = 1'b0; e.last = 1; e.writes = 1'b0;
        base = base_tbl[f3];
        if (w[6:0] == 7'h33) begin
            if (f3 == 3'd0 && f7 == 7'h20) base = "sub";
            else if (f7 != 7'h00) base = "";
            if (is_ext(base) && !EXT) base = "";
            if (base != "") begin
                e.kind = X_ALU; e.alu = alu_of(base); e.last = 3; e.writes = 1'b1;
            end
        end else if (w[6:0] == 7'h13) begin
            if ((base == "sll" || base == "srl") && w[31:26] != 6'd0) base = "";
            if (is_ext(base) && !EXT) base = "";
            if (base != "") begin
                e.kind = X_ALU; e.alu = alu_of(base); e.last = 3; e.writes = 1'b1;
                e.mux_0 = 1'b1; e.imm = w[31:20]; e.imm_care = 1'b1;
            end
        end else if (w[6:0] == 7'h03 && f3 == 3'd3) begin
            e.kind = X_LD; e.last = 4; e.writes = 1'b1; e.mux_0 = 1'b1; e.mux_1 = 1'b1;
            e.imm = w[31:20]; e.imm_care = 1'b1;
        end else if (w[6:0] == 7'h23 && f3 == 3'd3) begin
            e.kind = X_SD; e.last = 3; e.mux_0 = 1'b1;
            e.imm = {w[31:25], w[11:7]}; e.imm_care = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [37:0] all_outputs();
        return {cu_instr_ready, cu_rf_addr_a, cu_rf_addr_b, cu_rf_write_addr, cu_rf_write_en,
                cu_immediate, cu_mux_0_sel, cu_mux_1_sel, cu_mux_2_sel, cu_alu_operation,
                cu_dmem_write_en, cu_done, cu_illegal};
    endfunction

    task automatic tick();
        @(posedge cu_clk);
        #1;
    endtask

    // Hand one word over and check every cycle of its life, then the ready cycle after it
    task automatic run_instr(input logic [31:0] w, input string tag);
        exp_t        e;
        int          waited;
        logic [5:0]  s_obs, s_exp;
        logic [31:0] f_obs, f_exp;
        e = model(w);
        waited = 0;
        while (!cu_instr_ready && waited < 20) begin
            tick();
            waited++;
        end
        n_cmp++;
        if (cu_instr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s ready-wait: ready=%b want 1", tag, cu_instr_ready);
            return;
        end
        cu_instr       = w;
        cu_instr_valid = 1'b1;
        tick();
        for (int c = 1; c <= e.last; c++) begin
            s_obs = {cu_instr_ready, cu_illegal, cu_done, cu_rf_write_en, cu_dmem_write_en, cu_mux_2_sel};
            s_exp = {1'b0,
                     (e.kind == X_BAD) && (c == 1),
                     (e.kind != X_BAD) && (c == e.last),
                     e.writes && (c == e.last) && (w[11:7] != 5'd0),
                     (e.kind == X_SD) && (c == 3),
                     (e.kind == X_SD) && (c == 3)};
            n_cmp++;
            if (s_obs !== s_exp) begin
                n_fail++;
                $display("FAIL %s w=%h c%0d strobes{rdy,ill,done,rfwe,dmwe,mux2}: got %b want %b",
                         tag, w, c, s_obs, s_exp);
            end
            if (e.kind != X_BAD) begin
                f_obs = {cu_rf_addr_a, cu_rf_addr_b, cu_rf_write_addr,
                         e.imm_care ? cu_immediate : 12'h000,
                         cu_mux_0_sel, cu_mux_1_sel, cu_alu_operation};
                f_exp = {w[19:15], w[24:20], w[11:7], e.imm, e.mux_0, e.mux_1, e.alu};
                n_cmp++;
                if (f_obs !== f_exp) begin
                    n_fail++;
                    $display("FAIL %s w=%h c%0d fields{a,b,wa,imm,m0,m1,alu}: got %h want %h",
                             tag, w, c, f_obs, f_exp);
                end
            end
            // Busy cycles: valid and the word are noise the unit must ignore
            cu_instr_valid = 1'($urandom_range(0, 1));
            cu_instr       = $urandom();
            tick();
        end
        cu_instr_valid = 1'b0;
        n_cmp++;
        if (cu_instr_ready !== 1'b1 || cu_done !== 1'b0 || cu_illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL %s w=%h post-ready{rdy,done,ill}: got %b%b%b want 100",
                     tag, w, cu_instr_ready, cu_done, cu_illegal);
        end
    endtask

    task automatic test_reset();
        logic [37:0] o;
        cu_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cu_instr_valid = 1'($urandom_range(0, 1));
            cu_instr       = $urandom();
            tick();
        end
        o = all_outputs();
        n_cmp++;
        if (o !== 38'd0) begin
            n_fail++;
            $display("FAIL reset outputs: got %h want 0", o);
        end
        cu_instr_valid = 1'b0;
        cu_rst         = 1'b0;
        #1;
        n_cmp++;
        if (cu_instr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset ready-after: got %b want 1", cu_instr_ready);
        end
    endtask

    task automatic test_directed();
        run_instr(32'h002081B3, "add_x3_x1_x2");
        run_instr(32'h02A00293, "addi_x5_x0_42");
        run_instr(32'h0080B303, "ld_x6_8_x1");
        run_instr(32'h00613823, "sd_x6_16_x2");
        run_instr(32'h40208133, "sub_x2_x1_x2");
        run_instr(32'h00208033, "add_rd0");
        run_instr(32'h0FF0C413, "xori_x8_x1_255");
    endtask

    task automatic test_illegal();
        run_instr(32'hFFFFFFFF, "illegal_ones");
        run_instr(32'h002093B3, "sll_x7_x1_x2");
        run_instr(32'h00612823, "sw_not_sd");
        run_instr(32'h0080A303, "lw_not_ld");
    endtask

    task automatic test_reset_mid_instr();
        logic [37:0] o;
        cu_instr       = 32'h0080B303;
        cu_instr_valid = 1'b1;
        tick();
        cu_instr_valid = 1'b0;
        tick();
        n_cmp++;
        if ({cu_instr_ready, cu_done, cu_rf_write_en, cu_dmem_write_en} !== 4'b0000) begin
            n_fail++;
            $display("FAIL midrst c2{rdy,done,rfwe,dmwe}: got %b%b%b%b want 0000",
                     cu_instr_ready, cu_done, cu_rf_write_en, cu_dmem_write_en);
        end
        cu_rst         = 1'b1;
        cu_instr_valid = 1'b1;
        tick();
        o = all_outputs();
        n_cmp++;
        if (o !== 38'd0) begin
            n_fail++;
            $display("FAIL midrst outputs in reset: got %h want 0", o);
        end
        cu_rst         = 1'b0;
        cu_instr_valid = 1'b0;
        #1;
        n_cmp++;
        if (cu_instr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst ready-after: got %b want 1", cu_instr_ready);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if ({cu_done, cu_rf_write_en, cu_dmem_write_en, cu_illegal} !== 4'b0000) begin
                n_fail++;
                $display("FAIL midrst quiet%0d{done,rfwe,dmwe,ill}: got %b%b%b%b want 0000", i,
                         cu_done, cu_rf_write_en, cu_dmem_write_en, cu_illegal);
            end
        end
        run_instr(32'h002081B3, "add_after_reset");
    endtask

    task automatic test_back_to_back();
        logic [31:0] w;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [11:0] imm;
        for (int n = 0; n < 150; n++) begin
            rs1 = 5'($urandom);
            rs2 = 5'($urandom);
            rd  = 5'($urandom);
            f3  = 3'($urandom);
            imm = 12'($urandom);
            f7  = 7'h00;
            case ($urandom_range(0, 4))
                0: begin
                    if ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) f7 = 7'h20;
                    w = {f7, rs2, rs1, f3, rd, 7'h33};
                end
                1: begin
                    if (f3 == 3'd1 || f3 == 3'd5) imm[11:6] = ($urandom_range(0, 1) == 1) ? 6'h10 : 6'h00;
                    w = {imm, rs1, f3, rd, 7'h13};
                end
                2: begin
                    if ($urandom_range(0, 1) == 1) f3 = 3'd3;
                    w = {imm, rs1, f3, rd, 7'h03};
                end
                3: begin
                    if ($urandom_range(0, 1) == 1) f3 = 3'd3;
                    w = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
                end
                default: begin
                    w = $urandom();
                    if (w[6:0] == 7'h33 || w[6:0] == 7'h13) w[6:0] = 7'h7F;
                end
            endcase
            if ($urandom_range(0, 5) == 0) w[11:7] = 5'd0;
            if ($urandom_range(0, 3) == 0) begin
                cu_instr_valid = 1'b0;
                repeat ($urandom_range(1, 3)) tick();
            end
            run_instr(w, $sformatf("rand%0d", n));
        end
    endtask

    initial begin
        cu_rst         = 1'b1;
        cu_instr       = 32'd0;
        cu_instr_valid = 1'b0;
        test_reset();
        test_directed();
        test_illegal();
        test_reset_mid_instr();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
